dmem_scratchpad_model: RTL
==========================

DMEM_SCRATCHPAD_MODEL -- requirements
Module: dmem_scratchpad_model

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 40'h6000_0000: byte address of scratchpad word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 6: scratchpad holds 2^DEPTH_LOG2 64-bit words.
REQ-003 SHALL have parameter NACK_PERIOD, default 4: NACK injection interval (REQ-026).
REQ-004 SHALL have port clock  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port io_dmem_req_ready  out  1  request accept.
REQ-007 SHALL have port io_dmem_req_valid  in  1  request present.
REQ-008 SHALL have port io_dmem_req_bits_addr  in  40  byte address.
REQ-009 SHALL have port io_dmem_req_bits_tag  in  7  request tag.
REQ-010 SHALL have port io_dmem_req_bits_cmd  in  5  5'b00000 read (M_XRD), 5'b00001 write (M_XWR).
REQ-011 SHALL have port io_dmem_req_bits_typ  in  3  typ[1:0] size log2, typ[2] unsigned.
REQ-012 SHALL have port io_dmem_s1_kill  in  1  cancels request in stage 1.
REQ-013 SHALL have port io_dmem_s1_data_data  in  64  store data, lane-aligned, sampled in stage 1.
REQ-014 SHALL have port io_dmem_s2_nack  out  1  stage-2 negative acknowledge.
REQ-015 SHALL have port io_dmem_resp_valid  out  1  read response valid.
REQ-016 SHALL have port io_dmem_resp_bits_tag  out  7  tag of responding request.
REQ-017 SHALL have port io_dmem_resp_bits_typ  out  3  typ of responding request.
REQ-018 SHALL have port io_dmem_resp_bits_data  out  64  extended load data.
REQ-019 SHALL have port io_dmem_s2_xcpt_ae_ld  out  1  load access fault.
REQ-020 SHALL have port io_dmem_s2_xcpt_ae_st  out  1  store access fault.
REQ-021 SHALL have port io_dmem_ordered  out  1  high when stages 1 and 2 are empty.

Function
REQ-022 SHALL pipeline s0->s1->s2: request accepted at cycle T (req_valid && req_ready) is in s1 at T+1, s2 at T+2; one acceptance per cycle, req_ready held 1 outside reset.
REQ-023 SHALL, at s1, sample s1_kill and s1_data_data; killed request becomes a bubble: no write, no response, no exception, no NACK, no NACK-counter advance.
REQ-024 SHALL compute in-window as BASE_ADDR <= addr < BASE_ADDR + 8*2^DEPTH_LOG2; word index addr[DEPTH_LOG2+2:3]; byte offset addr[2:0] with bits below size forced to 0.
REQ-025 SHALL, at s2 for an unkilled out-of-window request, pulse xcpt_ae_ld (read) or xcpt_ae_st (write) for exactly one cycle; no write, resp_valid low.
REQ-026 SHALL (when REQ-034 enabled) NACK every NACK_PERIOD-th unkilled in-window request (counter 1..NACK_PERIOD, wrapping): s2_nack one cycle, no write, no response.
REQ-027 SHALL, for in-window unNACKed write at s2, update bytes offset..offset+2^size-1 of the word from the same byte lanes of sampled data; resp_valid stays low.
REQ-028 SHALL, for in-window unNACKed read at s2, assert resp_valid one cycle with tag/typ; data = selected bytes shifted to bit 0, sign-extended if typ[2]=0, zero-extended otherwise; size 3 returns full word.
REQ-029 SHALL read memory after any write from an older request (write at T+2 visible to read accepted at T+1).
REQ-030 SHALL hold resp_valid, s2_nack, xcpt_ae_* mutually exclusive; unused cmd values treated as reads.
REQ-031 SHALL drive ordered = !(s1_valid || s2_valid).

Reset
REQ-032 SHALL, during reset: req_ready=0, resp_valid=0, s2_nack=0, xcpt_ae_*=0, resp tag/typ/data=0, ordered=1, NACK counter=1; in-flight s1/s2 requests discarded (no write, no response).
REQ-033 SHALL NOT reset scratchpad contents; first cycle after reset deasserts accepts requests.

Configuration
REQ-034 SHALL compile NACK injection only when DMEM_MODEL_NACK_EN is defined; undefined: s2_nack tied 0, no counter, every unkilled in-window request completes.

Verification
REQ-035 Write addr 40'h6000_0008 typ 3 data 64'h1122334455667788 then read same, tag 5 -> resp at accept+2, tag 5, data 64'h1122334455667788.
REQ-036 Byte write 8'hF0 at 40'h6000_0003 typ 0, read back typ 0 -> 64'hFFFF_FFFF_FFFF_FFF0; typ 4 -> 64'h0000_0000_0000_00F0.
REQ-037 Read addr 40'h5FFF_FFF8 -> xcpt_ae_ld one cycle at accept+2, resp_valid 0; write addr 40'h6000_0200 -> xcpt_ae_st.
REQ-038 Write with s1_kill=1 at accept+1, then read -> old data returned, no nack/ae.
REQ-039 DMEM_MODEL_NACK_EN, 8 back-to-back reads tags 0..7 -> s2_nack for tags 3 and 7 only; other six responses in order.
REQ-040 Reset asserted at accept+1 of a write -> no response, memory unchanged, ordered=1 during reset.

Source files
------------

// File: rtl/dmem_scratchpad_model.sv
// dmem_scratchpad_model: three-stage (s0/s1/s2) data-memory port backed by a
// 2^DEPTH_LOG2 x 64-bit scratchpad mapped at BASE_ADDR. Requests outside the
// window raise a one-cycle access fault at s2. Optional periodic NACK
// injection is compiled in only when DMEM_MODEL_NACK_EN is defined; without
// it s2_nack is tied low and every unkilled in-window request completes.
module dmem_scratchpad_model #(
  parameter logic [39:0] BASE_ADDR   = 40'h6000_0000,
  parameter int          DEPTH_LOG2  = 6,
  parameter int          NACK_PERIOD = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_dmem_req_ready,
  input  logic        io_dmem_req_valid,
  input  logic [39:0] io_dmem_req_bits_addr,
  input  logic [6:0]  io_dmem_req_bits_tag,
  input  logic [4:0]  io_dmem_req_bits_cmd,
  input  logic [2:0]  io_dmem_req_bits_typ,
  input  logic        io_dmem_s1_kill,
  input  logic [63:0] io_dmem_s1_data_data,
  output logic        io_dmem_s2_nack,
  output logic        io_dmem_resp_valid,
  output logic [6:0]  io_dmem_resp_bits_tag,
  output logic [2:0]  io_dmem_resp_bits_typ,
  output logic [63:0] io_dmem_resp_bits_data,
  output logic        io_dmem_s2_xcpt_ae_ld,
  output logic        io_dmem_s2_xcpt_ae_st,
  output logic        io_dmem_ordered
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [40:0] LIMIT    = {1'b0, BASE_ADDR} + (41'd8 << DEPTH_LOG2);
  localparam logic [4:0]  CMD_XWR  = 5'b00001;

  // A non-positive NACK period is meaningless; nothing to build in that case.
  if (NACK_PERIOD < 1) begin : g_nack_period_guard
  end

  // ---------------------------------------------------------------- helpers
  function automatic logic in_window(input logic [39:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < LIMIT);
  endfunction

  // Byte offset within the word with the bits below the access size cleared.
  function automatic logic [2:0] lane_off(input logic [39:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return a[2:0];
      2'd1:    return {a[2:1], 1'b0};
      2'd2:    return {a[2], 2'b00};
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd0:    return 8'h01 << off;
      2'd1:    return 8'h03 << off;
      2'd2:    return 8'h0F << off;
      default: return 8'hFF;
    endcase
  endfunction

  // typ[2]=0 sign-extends, typ[2]=1 zero-extends; size 3 is the full word.
  function automatic logic [63:0] extend(input logic [63:0] sh, input logic [2:0] typ);
    case (typ[1:0])
      2'd0:    return typ[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    return typ[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    return typ[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  // ---------------------------------------------------------------- pipeline
  logic        w_req_fire;
  logic        r_s1_valid;
  logic [39:0] r_s1_addr;
  logic [6:0]  r_s1_tag;
  logic [4:0]  r_s1_cmd;
  logic [2:0]  r_s1_typ;
  logic        r_s2_valid;
  logic [39:0] r_s2_addr;
  logic [6:0]  r_s2_tag;
  logic [4:0]  r_s2_cmd;
  logic [2:0]  r_s2_typ;
  logic [63:0] r_s2_data;

  assign io_dmem_req_ready = !reset;
  assign w_req_fire        = io_dmem_req_valid && io_dmem_req_ready;

  // Stage valid bits; reset drops anything in flight, s1_kill turns s1 into a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_req_fire;
      r_s2_valid <= r_s1_valid && !io_dmem_s1_kill;
    end
  end

  // Stage payloads; qualified by the valid bits so they need no reset.
  always_ff @(posedge clock) begin
    if (w_req_fire) begin
      r_s1_addr <= io_dmem_req_bits_addr;
      r_s1_tag  <= io_dmem_req_bits_tag;
      r_s1_cmd  <= io_dmem_req_bits_cmd;
      r_s1_typ  <= io_dmem_req_bits_typ;
    end
    r_s2_addr <= r_s1_addr;
    r_s2_tag  <= r_s1_tag;
    r_s2_cmd  <= r_s1_cmd;
    r_s2_typ  <= r_s1_typ;
    r_s2_data <= io_dmem_s1_data_data;
  end

  // ---------------------------------------------------------------- s2 decode
  logic                  w_s2_live;
  logic                  w_s2_inwin;
  logic                  w_s2_is_wr;
  logic                  w_s2_nack;
  logic                  w_s2_wr_en;
  logic                  w_s2_rd_ok;
  logic [2:0]            w_s2_off;
  logic [7:0]            w_s2_mask;
  logic [DEPTH_LOG2-1:0] w_s2_idx;
  logic [DEPTH_LOG2-1:0] w_s1_idx;

  assign w_s2_live  = r_s2_valid && !reset;
  assign w_s2_inwin = in_window(r_s2_addr);
  assign w_s2_is_wr = (r_s2_cmd == CMD_XWR);
  assign w_s2_off   = lane_off(r_s2_addr, r_s2_typ[1:0]);
  assign w_s2_mask  = lane_mask(r_s2_typ[1:0], w_s2_off);
  assign w_s2_idx   = r_s2_addr[DEPTH_LOG2+2:3];
  assign w_s1_idx   = r_s1_addr[DEPTH_LOG2+2:3];

`ifdef DMEM_MODEL_NACK_EN
  localparam int             CW        = $clog2(NACK_PERIOD + 1);
  localparam logic [CW-1:0]  NACK_LAST = CW'(NACK_PERIOD);
  logic [CW-1:0] r_nack_cnt;

  // Counts unkilled in-window requests reaching s2; the last of each period is NACKed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_nack_cnt <= CW'(1);
    end else if (r_s2_valid && w_s2_inwin) begin
      r_nack_cnt <= (r_nack_cnt == NACK_LAST) ? CW'(1) : r_nack_cnt + CW'(1);
    end
  end

  assign w_s2_nack = r_s2_valid && w_s2_inwin && (r_nack_cnt == NACK_LAST);
`else
  assign w_s2_nack = 1'b0;
`endif

  assign w_s2_wr_en = w_s2_live && w_s2_inwin && !w_s2_nack && w_s2_is_wr;
  assign w_s2_rd_ok = w_s2_live && w_s2_inwin && !w_s2_nack && !w_s2_is_wr;

  // ---------------------------------------------------------------- storage
  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rd_word;
  logic [7:0]  r_fwd_mask;
  logic [63:0] r_fwd_data;
  logic [63:0] w_s2_word;

  // Byte-lane write from s2; registered read addressed by the request in s1.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 8; b++) begin
      if (w_s2_wr_en && w_s2_mask[b]) begin
        r_mem[w_s2_idx][b*8 +: 8] <= r_s2_data[b*8 +: 8];
      end
    end
    r_rd_word <= r_mem[w_s1_idx];
  end

  // The s1 read and an s2 write to the same word share an edge; remember the
  // written lanes so the read sees the newer bytes.
  always_ff @(posedge clock) begin
    r_fwd_mask <= (w_s2_wr_en && (w_s2_idx == w_s1_idx)) ? w_s2_mask : 8'h00;
    r_fwd_data <= r_s2_data;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane_merge
    assign w_s2_word[gi*8 +: 8] = r_fwd_mask[gi] ? r_fwd_data[gi*8 +: 8] : r_rd_word[gi*8 +: 8];
  end

  // ---------------------------------------------------------------- outputs
  logic [63:0] w_s2_shifted;
  assign w_s2_shifted = w_s2_word >> {w_s2_off, 3'b000};

  // Response, NACK and fault strobes; all quiet and zeroed while in reset.
  always_comb begin
    io_dmem_resp_valid     = w_s2_rd_ok;
    io_dmem_resp_bits_tag  = 7'd0;
    io_dmem_resp_bits_typ  = 3'd0;
    io_dmem_resp_bits_data = 64'd0;
    if (!reset) begin
      io_dmem_resp_bits_tag  = r_s2_tag;
      io_dmem_resp_bits_typ  = r_s2_typ;
      io_dmem_resp_bits_data = extend(w_s2_shifted, r_s2_typ);
    end
    io_dmem_s2_nack       = w_s2_live && w_s2_nack;
    io_dmem_s2_xcpt_ae_ld = w_s2_live && !w_s2_inwin && !w_s2_is_wr;
    io_dmem_s2_xcpt_ae_st = w_s2_live && !w_s2_inwin && w_s2_is_wr;
    io_dmem_ordered       = reset || !(r_s1_valid || r_s2_valid);
  end

endmodule
